// File: rtl/mdom_wvb_acq_ctrl_pkg.sv
// mdom_wvb_acq_ctrl_pkg: shared types and constants for the waveform-buffer acquisition controller
//   state_t       : controller state encoding
//   sot_bit/eoe_bit : positions of the framing flags above the sample field in a buffer word
//   max_evt_len   : longest event (full pre + full post + trigger sample)
package mdom_wvb_acq_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, PREFILL, WAIT_TRIG, ACQ} state_t;
   function automatic int sot_bit(input int adc_bits);
      return adc_bits;
   endfunction
   function automatic int eoe_bit(input int adc_bits);
      return adc_bits + 1;
   endfunction
   function automatic int max_evt_len(input int pre_bits, input int post_bits);
      return 2**pre_bits - 1 + 2**post_bits - 1 + 1;
   endfunction
endpackage

// File: rtl/mdom_wvb_acq_ctrl_dline.sv
// mdom_wvb_pretrig_dline: pre-trigger delay line, 2**A-entry shift register with variable tap
//   clk, rst : clock, sync active-high reset (clears only the output register)
//   din      : sample shifted in every cycle
//   tap      : delay in samples; tap=0 passes din straight through
//   dout     : registered sample delayed by tap cycles relative to din
module mdom_wvb_pretrig_dline #(
   parameter int W = 12,
   parameter int A = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic [A-1:0] tap,
   output logic [W-1:0] dout
);
   localparam int D = 2**A;
   logic [W-1:0] sr [D];
   always_ff @(posedge clk) begin
      sr[0] <= din;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
   end
   // sr[i] holds din from i+1 cycles ago, so a delay of tap needs sr[tap-1]
   always_ff @(posedge clk) begin
      if (rst) dout <= '0;
      else     dout <= (tap == '0) ? din : sr[tap - 1'b1];
   end
endmodule

// File: rtl/mdom_wvb_acq_ctrl.sv
// mdom_wvb_acq_ctrl: trigger selection/qualification and framed writes into the waveform buffer
//   clk, rst      : clock, sync active-high reset
//   adc_data      : ADC sample, valid every cycle
//   discr_trig    : discriminator level (rising edge triggers when trig_mode=0)
//   sw_trig       : software trigger pulse
//   arm, trig_mode, cnst_run, cnst_conf, pre_conf, post_conf : configuration bundle fields
//   wvb_full      : buffer lacks room for a maximum-length event
//   wvb_wr_en     : write strobe
//   wvb_wr_data   : {eoe, sot, sample}
//   armed         : controller not idle
//   trig_drop     : pulse when a qualified trigger is refused for lack of room
module mdom_wvb_acq_ctrl
   import mdom_wvb_acq_ctrl_pkg::*;
#(
   parameter int P_ADC_BITS  = 12,
   parameter int P_PRE_BITS  = 5,
   parameter int P_POST_BITS = 8,
   parameter int P_CNST_BITS = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [P_ADC_BITS-1:0]  adc_data,
   input  logic                   discr_trig,
   input  logic                   sw_trig,
   input  logic                   arm,
   input  logic                   trig_mode,
   input  logic                   cnst_run,
   input  logic [P_CNST_BITS-1:0] cnst_conf,
   input  logic [P_PRE_BITS-1:0]  pre_conf,
   input  logic [P_POST_BITS-1:0] post_conf,
   input  logic                   wvb_full,
   output logic                   wvb_wr_en,
   output logic [P_ADC_BITS+1:0]  wvb_wr_data,
   output logic                   armed,
   output logic                   trig_drop
);
   localparam int C_BITS = $clog2(max_evt_len(P_PRE_BITS, P_POST_BITS) + 1);
   localparam int SOT = sot_bit(P_ADC_BITS);
   localparam int EOE = eoe_bit(P_ADC_BITS);
   state_t state, state_n;
   logic [P_PRE_BITS-1:0]  pre_l;
   logic [P_POST_BITS-1:0] post_l;
   logic                   mode_l;
   logic [C_BITS-1:0]      cnt, span;
   logic [P_CNST_BITS-1:0] cnst_cnt;
   logic                   cnst_pulse, discr_q, trig_any, accept, refuse, sot, eoe;
   logic [P_ADC_BITS-1:0]  sample;
   mdom_wvb_pretrig_dline #(.W(P_ADC_BITS), .A(P_PRE_BITS)) u_dline (
      .clk  (clk),
      .rst  (rst),
      .din  (adc_data),
      .tap  (pre_l),
      .dout (sample)
   );
   assign span     = C_BITS'(pre_l) + C_BITS'(post_l);
   assign trig_any = sw_trig | cnst_pulse | (~mode_l & discr_trig & ~discr_q);
   assign armed    = state != IDLE;
   assign wvb_wr_data[P_ADC_BITS-1:0] = sample;
   assign wvb_wr_data[SOT] = sot;
   assign wvb_wr_data[EOE] = eoe;
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      refuse  = 1'b0;
      case (state)
         IDLE:      state_n = arm ? PREFILL : IDLE;
         PREFILL:   state_n = (cnt <= C_BITS'(1)) ? WAIT_TRIG : PREFILL;
         WAIT_TRIG: begin
            if (!arm) state_n = IDLE;
            else if (trig_any) begin
               refuse  = wvb_full;
               accept  = ~wvb_full;
               state_n = wvb_full ? WAIT_TRIG : ACQ;
            end
         end
         default:   state_n = (cnt != '0) ? ACQ : (arm ? WAIT_TRIG : IDLE);
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         pre_l      <= '0;
         post_l     <= '0;
         mode_l     <= 1'b0;
         discr_q    <= 1'b0;
         cnst_cnt   <= '0;
         cnst_pulse <= 1'b0;
         wvb_wr_en  <= 1'b0;
         sot        <= 1'b0;
         eoe        <= 1'b0;
         trig_drop  <= 1'b0;
      end else begin
         state      <= state_n;
         discr_q    <= discr_trig;
         // >= rather than == so a period shortened on the fly wraps at once
         cnst_cnt   <= (!cnst_run || cnst_cnt >= cnst_conf) ? '0 : cnst_cnt + 1'b1;
         cnst_pulse <= cnst_run && cnst_cnt >= cnst_conf;
         trig_drop  <= refuse;
         // cnt counts remaining words after the one being presented
         wvb_wr_en  <= accept | (state == ACQ && cnt != '0);
         sot        <= accept;
         eoe        <= accept ? (span == '0) : (state == ACQ && cnt == C_BITS'(1));
         if (state == IDLE && arm) begin
            pre_l  <= pre_conf;
            post_l <= post_conf;
            mode_l <= trig_mode;
            cnt    <= C_BITS'(pre_conf);
         end else if (state == PREFILL)
            cnt <= cnt - 1'b1;
         else if (accept)
            cnt <= span;
         else if (state == ACQ && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_mdom_wvb_acq_ctrl.sv
// tb_mdom_wvb_acq_ctrl: directed self-checking bench for mdom_wvb_acq_ctrl
module tb_mdom_wvb_acq_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] adc_data;
   logic        discr_trig, sw_trig, arm, trig_mode, cnst_run, wvb_full;
   logic [11:0] cnst_conf;
   logic [4:0]  pre_conf;
   logic [7:0]  post_conf;
   logic        wvb_wr_en, armed, trig_drop;
   logic [13:0] wvb_wr_data;
   int          n = 0;
   int          checks = 0;
   int          errors = 0;
   int          c, d, r, t, a;
   logic        exp_we;

   mdom_wvb_acq_ctrl dut (
      .clk(clk), .rst(rst), .adc_data(adc_data), .discr_trig(discr_trig), .sw_trig(sw_trig),
      .arm(arm), .trig_mode(trig_mode), .cnst_run(cnst_run), .cnst_conf(cnst_conf),
      .pre_conf(pre_conf), .post_conf(post_conf), .wvb_full(wvb_full), .wvb_wr_en(wvb_wr_en),
      .wvb_wr_data(wvb_wr_data), .armed(armed), .trig_drop(trig_drop)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
      adc_data = 12'(n);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   initial begin
      rst = 1; adc_data = 0; discr_trig = 0; sw_trig = 0; arm = 0; trig_mode = 0;
      cnst_run = 0; wvb_full = 0; cnst_conf = 0; pre_conf = 0; post_conf = 0;
      repeat (3) tick();
      chk("rst_wr_en", 32'(wvb_wr_en), 0);
      chk("rst_wr_data", 32'(wvb_wr_data), 0);
      chk("rst_armed", 32'(armed), 0);
      chk("rst_drop", 32'(trig_drop), 0);
      // pre=4 post=10 software trigger at cycle 100
      rst = 0; pre_conf = 4; post_conf = 10; trig_mode = 1; arm = 1;
      while (n != 100) tick();
      chk("t1_armed", 32'(armed), 1);
      sw_trig = 1;
      tick();
      sw_trig = 0;
      for (int k = 0; k < 15; k++) begin
         chk("t1_we", 32'(wvb_wr_en), 1);
         chk("t1_sample", 32'(wvb_wr_data[11:0]), 32'(96 + k));
         chk("t1_sot", 32'(wvb_wr_data[12]), 32'(k == 0));
         chk("t1_eoe", 32'(wvb_wr_data[13]), 32'(k == 14));
         tick();
      end
      chk("t1_end", 32'(wvb_wr_en), 0);
      // discriminator edge, single-word events
      arm = 0;
      tick(); tick();
      chk("t2_idle", 32'(armed), 0);
      pre_conf = 0; post_conf = 0; trig_mode = 0; arm = 1;
      repeat (3) tick();
      discr_trig = 1; d = n; c = 0;
      repeat (20) begin
         tick();
         c += int'(wvb_wr_en);
         if (wvb_wr_en) begin
            chk("t2_flags", 32'(wvb_wr_data[13:12]), 3);
            chk("t2_sample", 32'(wvb_wr_data[11:0]), 32'(d));
         end
      end
      chk("t2_count", 32'(c), 1);
      discr_trig = 0;
      tick();
      discr_trig = 1; d = n;
      tick();
      discr_trig = 0;
      chk("t2_retrig", 32'(wvb_wr_en), 1);
      chk("t2_retrig_sample", 32'(wvb_wr_data[11:0]), 32'(d));
      // constant-rate trigger, discriminator ignored in trig_mode=1
      arm = 0;
      tick(); tick();
      pre_conf = 2; post_conf = 5; trig_mode = 1; arm = 1;
      repeat (5) tick();
      cnst_conf = 99; cnst_run = 1; r = n;
      for (int i = 1; i <= 230; i++) begin
         discr_trig = ~discr_trig;
         tick();
         exp_we = (i >= 101) && ((i - 101) % 100 < 8);
         chk("t3_we", 32'(wvb_wr_en), 32'(exp_we));
         if (exp_we) chk("t3_sample", 32'(wvb_wr_data[11:0]), 32'(n - 3));
      end
      cnst_run = 0; discr_trig = 0;
      repeat (10) tick();
      // full buffer refuses trigger; trigger during ACQ ignored
      wvb_full = 1; sw_trig = 1;
      tick();
      sw_trig = 0;
      chk("t4_drop", 32'(trig_drop), 1);
      chk("t4_no_we", 32'(wvb_wr_en), 0);
      tick();
      chk("t4_drop_pulse", 32'(trig_drop), 0);
      chk("t4_no_we2", 32'(wvb_wr_en), 0);
      wvb_full = 0; sw_trig = 1;
      tick();
      sw_trig = 0; c = 0;
      for (int i = 0; i < 12; i++) begin
         c += int'(wvb_wr_en);
         chk("t4_acq_drop", 32'(trig_drop), 0);
         sw_trig = (i == 3); wvb_full = (i == 3);
         tick();
      end
      sw_trig = 0; wvb_full = 0;
      chk("t4_count", 32'(c), 8);
      // arm falls mid-event; pre_conf change while armed is ignored
      arm = 0;
      tick(); tick();
      pre_conf = 9; post_conf = 10; arm = 1;
      repeat (12) tick();
      pre_conf = 3; sw_trig = 1; t = n;
      tick();
      sw_trig = 0;
      for (int k = 0; k < 20; k++) begin
         chk("t5_we", 32'(wvb_wr_en), 1);
         chk("t5_sample", 32'(wvb_wr_data[11:0]), 32'(t - 9 + k));
         chk("t5_eoe", 32'(wvb_wr_data[13]), 32'(k == 19));
         if (k == 3) arm = 0;
         tick();
      end
      chk("t5_end_we", 32'(wvb_wr_en), 0);
      chk("t5_end_armed", 32'(armed), 0);
      // reset mid-event, then re-arm with pre=3
      post_conf = 10; arm = 1;
      repeat (6) tick();
      sw_trig = 1;
      tick();
      sw_trig = 0;
      chk("t6_we", 32'(wvb_wr_en), 1);
      tick(); tick();
      rst = 1;
      tick();
      chk("t6_rst_we", 32'(wvb_wr_en), 0);
      chk("t6_rst_eoe", 32'(wvb_wr_data[13]), 0);
      chk("t6_rst_armed", 32'(armed), 0);
      rst = 0; sw_trig = 1; a = n;
      repeat (4) begin
         tick();
         chk("t6_prefill_we", 32'(wvb_wr_en), 0);
      end
      tick();
      sw_trig = 0;
      chk("t6_first_we", 32'(wvb_wr_en), 1);
      chk("t6_first_sot", 32'(wvb_wr_data[12]), 1);
      chk("t6_first_sample", 32'(wvb_wr_data[11:0]), 32'(a + 1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdom_wvb_acq_ctrl.md
Name: mdom_wvb_acq_ctrl

Overview:
- Waveform-buffer acquisition controller, directly downstream of the wvb config bundle fan-out.
- Consumes the fanned-out arm, trig_mode, cnst_run, cnst_conf, pre_conf and post_conf fields, plus the ADC sample stream and trigger inputs.
- Selects and qualifies triggers and produces framed write strobes (pre-trigger + trigger + post-trigger samples) into the waveform buffer.
- test_conf is consumed elsewhere (test-pattern generator) and is not an input here.

Parameters:
- P_ADC_BITS, 12, ADC sample width.
- P_PRE_BITS, 5, pre_conf width; delay line depth is 2**P_PRE_BITS = 32.
- P_POST_BITS, 8, post_conf width.
- P_CNST_BITS, 12, cnst_conf width.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- adc_data  in  P_ADC_BITS  sample, valid every cycle.
- discr_trig  in  1  discriminator level; used only when trig_mode=0.
- sw_trig  in  1  single-cycle software trigger pulse.
- arm  in  1  level; from bundle.
- trig_mode  in  1  from bundle; 0 = discriminator rising edge enabled, 1 = discriminator ignored.
- cnst_run  in  1  from bundle; enables the constant-rate trigger.
- cnst_conf  in  P_CNST_BITS  constant-trigger period minus 1, in cycles.
- pre_conf  in  P_PRE_BITS  pre-trigger sample count.
- post_conf  in  P_POST_BITS  post-trigger sample count.
- wvb_full  in  1  buffer cannot accept one maximum-length event (287 words).
- wvb_wr_en  out  1  write strobe.
- wvb_wr_data  out  P_ADC_BITS+2  {eoe, sot, sample}.
- armed  out  1  state != IDLE.
- trig_drop  out  1  one-cycle pulse when a qualified trigger is refused because wvb_full=1.

Behaviour:
- Reset: all outputs are 0, state = IDLE, counters cleared, delay line contents are don't-care. Reset at any point, including mid-event, takes effect next cycle; no eoe is emitted for an aborted event.
- Trigger sources:
  - trig_any = sw_trig OR cnst_pulse OR (trig_mode==0 AND discr rising edge).
  - The discriminator edge is discr_trig=1 with the previous-cycle register = 0.
  - The constant counter runs while cnst_run=1 and clears while cnst_run=0. cnst_pulse asserts when the counter reaches cnst_conf, and the counter then wraps to 0. The first pulse occurs cnst_conf+1 cycles after cnst_run rises. cnst_conf=0 gives a pulse every cycle.
- Config latch: pre_conf, post_conf and trig_mode are latched on the IDLE->PREFILL transition and held until the block returns to IDLE. Changes while armed have no effect.
- Delay line: shifts adc_data every cycle regardless of state. The tap is selected by the latched pre value.
- States:
  - IDLE: if arm=1, go to PREFILL (load prefill count = pre).
  - PREFILL: count pre cycles, then go to WAIT_TRIG. pre=0 gives exactly one cycle in PREFILL. Triggers are ignored.
  - WAIT_TRIG:
    - arm=0 -> IDLE.
    - trig_any=1 and wvb_full=0 -> ACQ (load length = pre+post+1).
    - trig_any=1 and wvb_full=1 -> trig_drop=1 next cycle; remain in WAIT_TRIG.
  - ACQ: emit one word per cycle. On the last word, go to WAIT_TRIG if arm=1, else IDLE. No new PREFILL is needed because the delay line stays valid.
- Timing: a trigger accepted at cycle T produces wvb_wr_en=1 on cycles T+1 through T+1+pre+post. The word at T+1+k carries sample s[T-pre+k].
  - sot=1 only at k=0.
  - eoe=1 only at k=pre+post; when pre=post=0 the single word has sot=eoe=1.
  - Maximum event length is 31+255+1 = 287 words.
- During ACQ: triggers are ignored (not counted, no trig_drop). wvb_full is ignored; the upstream guarantee is room for a full event. arm falling mid-ACQ does not truncate the event.
- Simultaneous sources in one cycle produce one event.
- The counter width must hold 287, i.e. 9 bits.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/PREFILL/WAIT_TRIG/ACQ);
  - the word layout constants (eoe/sot bit positions);
  - max event length, computed as 2**P_PRE_BITS - 1 + 2**P_POST_BITS - 1 + 1.
- One sub-module: mdom_wvb_pretrig_dline, a 32-entry shift register with a variable tap and 1-cycle registered output.

Test Plan:
- pre=4, post=10, arm=1, ramp adc_data=n, sw_trig at cycle 100 -> 15 writes on cycles 101..115 with samples 96..110; sot at 101, eoe at 115.
- pre=0, post=0, trig_mode=0, discr_trig held high 20 cycles -> exactly one 1-word event with sot=eoe=1; no retrigger until discr_trig falls and rises again.
- cnst_run=1, cnst_conf=99, pre=2, post=5 -> 8-word events starting every 100 cycles; trig_mode=1 with discr_trig toggling adds no events.
- wvb_full=1 at trigger in WAIT_TRIG -> no writes, trig_drop one cycle; trigger during ACQ -> ignored, no trig_drop.
- arm falls at word 3 of a 20-word event -> all 20 words written, then IDLE and armed=0; pre_conf changed while armed -> next event still uses the latched value.
- rst asserted mid-ACQ -> wvb_wr_en=0 the next cycle, no eoe; re-arm -> PREFILL lasts pre cycles before any trigger is accepted.
